// File: rtl/undolog_meta_reader.sv
// undolog_meta_reader: walks an undo log, validates each entry header and
// issues one restore-copy command per non-empty entry.
module undolog_meta_reader (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_recover,
  input  logic [63:0] ulog_offset,
  input  logic [63:0] ulog_limit,
  output logic        rd_req_valid,
  input  logic        rd_req_ready,
  output logic [63:0] rd_req_addr,
  input  logic        rd_resp_valid,
  input  logic [63:0] rd_resp_data,
  output logic        rst_valid,
  input  logic        rst_ready,
  output logic [63:0] rst_dst,
  output logic [63:0] rst_src,
  output logic [31:0] rst_size,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] entries_restored
);
  typedef enum logic [2:0] {IDLE, REQ, WAIT, CHECK, ISSUE, FIN} state_t;
  state_t      r_state, w_next;
  logic [63:0] r_cur, r_lim, r_w0, r_w1, r_w2;
  logic [1:0]  r_idx;
  logic        r_err;
  logic [15:0] r_cnt;
  logic [32:0] w_rnd;
  logic [64:0] w_adv;
  logic        w_start_over, w_adv_over, w_end, w_bad, w_zero, w_stop, w_advance;
  assign w_rnd        = ({1'b0, r_w0[31:0]} + 33'd7) & ~33'd7;
  assign w_adv        = {1'b0, r_cur} + 65'd24 + {32'd0, w_rnd};
  // the next header must fit entirely below the limit before it is read
  assign w_start_over = ({1'b0, ulog_offset} + 65'd24) > {1'b0, ulog_limit};
  assign w_adv_over   = ({1'b0, w_adv[63:0]} + 65'd24) > {1'b0, r_lim};
  assign w_stop       = w_adv[64] | w_adv_over;
  assign w_end        = (r_w0[63:48] != 16'hA5C3) | ~r_w0[47];
  assign w_bad        = r_w2 != (r_w0 ^ r_w1);
  assign w_zero       = r_w0[31:0] == 32'd0;
  assign w_advance    = (r_state == CHECK && !w_end && !w_bad && w_zero) || (r_state == ISSUE && rst_ready);
  always_ff @(posedge clk) r_state <= reset ? IDLE : w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = start_recover ? (w_start_over ? FIN : REQ) : IDLE;
      REQ:     w_next = rd_req_ready ? WAIT : REQ;
      WAIT:    w_next = rd_resp_valid ? (r_idx == 2'd2 ? CHECK : REQ) : WAIT;
      CHECK:   w_next = (w_end | w_bad) ? FIN : w_zero ? (w_stop ? FIN : REQ) : ISSUE;
      ISSUE:   w_next = rst_ready ? (w_stop ? FIN : REQ) : ISSUE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cur <= '0;
      r_lim <= '0;
      r_w0  <= '0;
      r_w1  <= '0;
      r_w2  <= '0;
      r_idx <= '0;
      r_err <= 1'b0;
      r_cnt <= '0;
    end else begin
      if (r_state == IDLE && start_recover) begin
        r_cur <= ulog_offset;
        r_lim <= ulog_limit;
        r_err <= 1'b0;
        r_cnt <= '0;
        r_idx <= '0;
      end
      if (r_state == WAIT && rd_resp_valid) begin
        if (r_idx == 2'd0) r_w0 <= rd_resp_data;
        if (r_idx == 2'd1) r_w1 <= rd_resp_data;
        if (r_idx == 2'd2) r_w2 <= rd_resp_data;
        r_idx <= r_idx == 2'd2 ? 2'd0 : r_idx + 2'd1;
      end
      if (r_state == CHECK && !w_end && w_bad) r_err <= 1'b1;
      if (w_advance) begin
        r_cur <= w_adv[63:0];
        if (w_adv[64]) r_err <= 1'b1;
      end
      if (r_state == ISSUE && rst_ready) r_cnt <= r_cnt == 16'hFFFF ? r_cnt : r_cnt + 16'd1;
    end
  end
  assign rd_req_valid     = r_state == REQ;
  assign rd_req_addr      = rd_req_valid ? r_cur + {59'd0, r_idx, 3'd0} : '0;
  assign rst_valid        = r_state == ISSUE;
  assign rst_dst          = rst_valid ? r_w1 : '0;
  assign rst_src          = rst_valid ? r_cur + 64'd24 : '0;
  assign rst_size         = rst_valid ? r_w0[31:0] : '0;
  assign busy             = r_state != IDLE && r_state != FIN;
  assign done             = r_state == FIN;
  assign error            = r_err;
  assign entries_restored = r_cnt;
endmodule
